// File: rtl/pusch_pkg.sv
// rtl/pusch_pkg.sv - shared widths, limits and FSM state type for the PUSCH interleaver controller
package pusch_pkg;

  localparam int E_W   = 17;
  localparam int QM_W  = 3;
  localparam int MAX_E = 93996;

  localparam logic [QM_W-1:0] QM_1 = 3'd1;
  localparam logic [QM_W-1:0] QM_2 = 3'd2;
  localparam logic [QM_W-1:0] QM_4 = 3'd4;
  localparam logic [QM_W-1:0] QM_6 = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_DRAIN,
    ST_GAP,
    ST_HALT
  } state_e;

  function automatic logic qm_legal(input logic [QM_W-1:0] qm);
    return (qm == QM_1) || (qm == QM_2) || (qm == QM_4) || (qm == QM_6);
  endfunction

endpackage

// File: rtl/interleaver_cfg_check.sv
// rtl/interleaver_cfg_check.sv - combinational legality check of a per-CB (E, Qm) config
module interleaver_cfg_check
  import pusch_pkg::*;
(
  input  logic [E_W-1:0]  e,
  input  logic [QM_W-1:0] qm,
  output logic            ok
);

  assign ok = (e != '0) && (e <= E_W'(MAX_E)) && qm_legal(qm);

endmodule

// File: rtl/interleaver_ctrl.sv
// rtl/interleaver_ctrl.sv - sequences PUSCH code blocks through the bit interleaver
module interleaver_ctrl
  import pusch_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int GAP_CYC = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [E_W-1:0]  cfg_E,
  input  logic [QM_W-1:0] cfg_Qm,
  input  logic            cfg_last,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_bit,
  output logic            il_active,
  output logic            il_data,
  output logic [E_W-1:0]  il_E,
  output logic [QM_W-1:0] il_Qm,
  input  logic            il_valid_out,
  output logic            cb_done,
  output logic            tb_done,
  output logic [7:0]      cb_cnt,
  output logic            cfg_err,
  output logic            err_timeout,
  output logic            busy
);

  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

  state_e           state_q, state_d;
  logic [E_W-1:0]   il_e_q, il_e_d;
  logic [QM_W-1:0]  il_qm_q, il_qm_d;
  logic             last_q, last_d;
  logic [E_W-1:0]   fill_cnt_q, fill_cnt_d;
  logic [E_W-1:0]   out_cnt_q, out_cnt_d;
  logic [E_W-1:0]   drain_tmr_q, drain_tmr_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [7:0]       cb_cnt_q, cb_cnt_d;
  logic             cfg_err_q, cfg_err_d;
  logic             err_timeout_q, err_timeout_d;

  logic             cfg_ok;
  logic             beat_last;
  logic             out_last;
  logic             drain_expired;
  logic             gap_end;
  logic [E_W:0]     drain_limit;

  interleaver_cfg_check u_cfg_check (
    .e  (cfg_E),
    .qm (cfg_Qm),
    .ok (cfg_ok)
  );

  // One extra bit so E + TIMEOUT can never wrap
  assign drain_limit   = {1'b0, il_e_q} + (E_W+1)'(TIMEOUT) - (E_W+1)'(1);
  assign beat_last     = (fill_cnt_q == il_e_q - E_W'(1));
  assign out_last      = (out_cnt_q == il_e_q - E_W'(1));
  assign drain_expired = ({1'b0, drain_tmr_q} == drain_limit);
  assign gap_end       = (state_q == ST_GAP) && (gap_cnt_q == GAP_LAST);

  always_comb begin
    state_d       = state_q;
    il_e_d        = il_e_q;
    il_qm_d       = il_qm_q;
    last_d        = last_q;
    fill_cnt_d    = fill_cnt_q;
    out_cnt_d     = out_cnt_q;
    drain_tmr_d   = drain_tmr_q;
    gap_cnt_d     = gap_cnt_q;
    cb_cnt_d      = cb_cnt_q;
    cfg_err_d     = 1'b0;
    err_timeout_d = err_timeout_q;

    case (state_q)
      ST_IDLE: begin
        if (cfg_valid) begin
          if (cfg_ok) begin
            il_e_d     = cfg_E;
            il_qm_d    = cfg_Qm;
            last_d     = cfg_last;
            fill_cnt_d = '0;
            state_d    = ST_FILL;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_FILL: begin
        if (in_valid) begin
          if (beat_last) begin
            fill_cnt_d  = '0;
            out_cnt_d   = '0;
            drain_tmr_d = '0;
            state_d     = ST_DRAIN;
          end else begin
            fill_cnt_d = fill_cnt_q + E_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        drain_tmr_d = drain_tmr_q + E_W'(1);
        // A completing read-out beat wins over an expiring timer in the same cycle
        if (il_valid_out && out_last) begin
          gap_cnt_d = '0;
          state_d   = ST_GAP;
        end else begin
          if (il_valid_out) begin
            out_cnt_d = out_cnt_q + E_W'(1);
          end
          if (drain_expired) begin
            err_timeout_d = 1'b1;
            state_d       = ST_HALT;
          end
        end
      end
      ST_GAP: begin
        if (gap_end) begin
          cb_cnt_d = last_q ? 8'd0 : cb_cnt_q + 8'd1;
          state_d  = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      il_e_q        <= '0;
      il_qm_q       <= '0;
      last_q        <= 1'b0;
      fill_cnt_q    <= '0;
      out_cnt_q     <= '0;
      drain_tmr_q   <= '0;
      gap_cnt_q     <= '0;
      cb_cnt_q      <= '0;
      cfg_err_q     <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      il_e_q        <= il_e_d;
      il_qm_q       <= il_qm_d;
      last_q        <= last_d;
      fill_cnt_q    <= fill_cnt_d;
      out_cnt_q     <= out_cnt_d;
      drain_tmr_q   <= drain_tmr_d;
      gap_cnt_q     <= gap_cnt_d;
      cb_cnt_q      <= cb_cnt_d;
      cfg_err_q     <= cfg_err_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign cfg_ready   = (state_q == ST_IDLE);
  assign in_ready    = (state_q == ST_FILL);
  assign il_active   = in_ready & in_valid;
  assign il_data     = in_ready & in_bit;
  assign il_E        = il_e_q;
  assign il_Qm       = il_qm_q;
  assign cb_done     = gap_end;
  assign tb_done     = gap_end & last_q;
  assign cb_cnt      = cb_cnt_q;
  assign cfg_err     = cfg_err_q;
  assign err_timeout = err_timeout_q;
  assign busy        = (state_q != ST_IDLE);

endmodule
